// File: rtl/rx_deframer_pkg.sv
// rx_deframer shared constants: K codes, payload type tags,
// error causes, CRC polynomial and FSM state encoding.
package rx_deframer_pkg;

  localparam logic [7:0] K_SOF    = 8'hFB;
  localparam logic [7:0] K_EOF    = 8'hFD;
  localparam logic [7:0] K_IDLE   = 8'hBC;
  localparam logic [7:0] CRC_POLY = 8'h07;

  typedef enum logic [1:0] {
    T_MID    = 2'b00,
    T_FIRST  = 2'b01,
    T_LAST   = 2'b10,
    T_SINGLE = 2'b11
  } type_e;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_CRC   = 3'd1,
    ERR_K     = 3'd2,
    ERR_SOF   = 3'd3,
    ERR_LEN   = 3'd4,
    ERR_EMPTY = 3'd5,
    ERR_ALIGN = 3'd6
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUNT,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/crc8_update.sv
// Combinational CRC-8 step (poly 0x07, MSB first).
// Ports: crc = running value, data = byte, crc_next = result.
module crc8_update
  import rx_deframer_pkg::*;
(
  input  logic [7:0] crc,
  input  logic [7:0] data,
  output logic [7:0] crc_next
);

  always_comb begin
    crc_next = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (crc_next[7]) begin
        crc_next = {crc_next[6:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_next = {crc_next[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/rx_deframer.sv
// Receive deframer: strips SOF/CRC/EOF, tags payload bytes,
// checks CRC-8 and keeps good/bad frame counters.
// Ports: clk/rst, rx_aligned/rx_valid/rx_data/rx_k in;
// out_valid/out_data/out_type, frame_ok/frame_err/err_code,
// frame_count (wraps), err_count (saturates) out.
module rx_deframer
  import rx_deframer_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_aligned,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_k,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic [1:0]       out_type,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);

  // cnt tracks non-K bytes taken in this frame (payload + CRC)
  localparam int LW = $clog2(MAX_LEN + 3);
  localparam logic [LW-1:0] LEN_LIM = LW'(MAX_LEN + 1);
  localparam logic [LW-1:0] TWO     = LW'(2);

  state_e           state, state_d;
  logic [7:0]       h1, h1_d;
  logic [7:0]       h2, h2_d;
  logic [7:0]       crc, crc_d, crc_h2;
  logic [LW-1:0]    cnt, cnt_d;
  logic             emitted, emitted_d;
  logic             ov_d;
  logic [7:0]       od_d;
  logic [1:0]       ot_d;
  logic             ok_d;
  logic             fe_d;
  logic [2:0]       ec_d;
  logic [CNT_W-1:0] fc_d;
  logic [CNT_W-1:0] erc_d;
  logic             is_sof;
  logic             is_eof;

  assign is_sof = rx_k && (rx_data == K_SOF);
  assign is_eof = rx_k && (rx_data == K_EOF);

  crc8_update u_crc (
    .crc      (crc),
    .data     (h2),
    .crc_next (crc_h2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      h1          <= '0;
      h2          <= '0;
      crc         <= '0;
      cnt         <= '0;
      emitted     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_type    <= '0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_d;
      h1          <= h1_d;
      h2          <= h2_d;
      crc         <= crc_d;
      cnt         <= cnt_d;
      emitted     <= emitted_d;
      out_valid   <= ov_d;
      out_data    <= od_d;
      out_type    <= ot_d;
      frame_ok    <= ok_d;
      frame_err   <= fe_d;
      err_code    <= ec_d;
      frame_count <= fc_d;
      err_count   <= erc_d;
    end
  end

  always_comb begin
    state_d   = state;
    h1_d      = h1;
    h2_d      = h2;
    crc_d     = crc;
    cnt_d     = cnt;
    emitted_d = emitted;
    ov_d      = 1'b0;
    od_d      = '0;
    ot_d      = '0;
    ok_d      = 1'b0;
    fe_d      = 1'b0;
    ec_d      = ERR_NONE;

    if (rx_valid) begin
      unique case (state)
        S_IDLE, S_DRAIN: begin
          state_d = S_IDLE;
          if (rx_aligned && is_sof) begin
            state_d   = S_HUNT;
            h1_d      = '0;
            h2_d      = '0;
            crc_d     = '0;
            cnt_d     = '0;
            emitted_d = 1'b0;
          end
        end
        S_HUNT: begin
          if (!rx_aligned) begin
            state_d = S_IDLE;
            fe_d    = 1'b1;
            ec_d    = ERR_ALIGN;
          end else if (is_sof) begin
            // restart: the new SOF opens a fresh frame
            fe_d      = 1'b1;
            ec_d      = ERR_SOF;
            h1_d      = '0;
            h2_d      = '0;
            crc_d     = '0;
            cnt_d     = '0;
            emitted_d = 1'b0;
          end else if (is_eof) begin
            state_d = S_DRAIN;
            if (cnt < TWO) begin
              fe_d = 1'b1;
              ec_d = ERR_EMPTY;
            end else begin
              // h2 is the last payload byte, h1 the CRC
              ov_d = 1'b1;
              od_d = h2;
              ot_d = emitted ? T_LAST : T_SINGLE;
              if (crc_h2 == h1) begin
                ok_d = 1'b1;
              end else begin
                fe_d = 1'b1;
                ec_d = ERR_CRC;
              end
            end
          end else if (rx_k) begin
            state_d = S_IDLE;
            fe_d    = 1'b1;
            ec_d    = ERR_K;
          end else if (cnt == LEN_LIM) begin
            state_d = S_IDLE;
            fe_d    = 1'b1;
            ec_d    = ERR_LEN;
          end else begin
            h1_d  = rx_data;
            h2_d  = h1;
            cnt_d = cnt + 1'b1;
            if (cnt >= TWO) begin
              ov_d      = 1'b1;
              od_d      = h2;
              ot_d      = emitted ? T_MID : T_FIRST;
              emitted_d = 1'b1;
              crc_d     = crc_h2;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    fc_d = frame_count;
    if (ok_d) begin
      fc_d = frame_count + 1'b1;
    end
    erc_d = err_count;
    if (fe_d && (err_count != {CNT_W{1'b1}})) begin
      erc_d = err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_deframer.sv
// Bench for rx_deframer: table vectors, corner sequences and
// random frames against a frame-level reference model.
module tb_rx_deframer;
  import rx_deframer_pkg::*;

  localparam int MAX_LEN = 64;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx_aligned = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_k = 1'b0;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [1:0]       out_type;
  logic             frame_ok;
  logic             frame_err;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] err_count;

  rx_deframer #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_aligned  (rx_aligned),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_k        (rx_k),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_type    (out_type),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  always #8 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic [1:0] t;
  } byte_t;

  typedef struct {
    int         cyc;
    logic       ok;
    logic       err;
    logic [2:0] code;
  } evt_t;

  typedef struct {
    int              n;
    logic [0:3][7:0] p;
    logic [7:0]      cx;
    logic            ok;
    logic [2:0]      code;
    int              nb;
  } vec_t;

  byte_t obs_b[$], exp_b[$];
  evt_t  obs_e[$], exp_e[$];

  int naso = 0;
  int nfail = 0;

  // reference model state
  bit         m_in = 0;
  logic [7:0] mq[$];
  int         m_ne = 0;
  int         m_fc = 0;
  int         m_ec = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        byte_t b;
        b.cyc = cyc; b.d = out_data; b.t = out_type;
        obs_b.push_back(b);
      end
      if (frame_ok || frame_err) begin
        evt_t e;
        e.cyc = cyc; e.ok = frame_ok; e.err = frame_err;
        e.code = frame_err ? err_code : 3'd0;
        obs_e.push_back(e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    naso++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC as remainder of M(x)*x^8 modulo x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [7:0] q[$],
                                         input int n);
    logic [8:0] r;
    logic [7:0] cur;
    logic       b;
    r = 9'd0;
    for (int i = 0; i < n * 8 + 8; i++) begin
      if (i < n * 8) begin
        cur = q[i / 8];
        b = cur[7 - (i % 8)];
      end else begin
        b = 1'b0;
      end
      r = {r[7:0], b};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  task automatic m_err(input int code, input int st);
    evt_t e;
    e.cyc = st; e.ok = 1'b0; e.err = 1'b1; e.code = 3'(code);
    exp_e.push_back(e);
    if (m_ec < (1 << CNT_W) - 1) m_ec++;
  endtask

  task automatic m_emit(input logic [7:0] d, input logic [1:0] t,
                        input int st);
    byte_t b;
    b.cyc = st; b.d = d; b.t = t;
    exp_b.push_back(b);
  endtask

  task automatic model(input bit v, input bit a, input bit k,
                       input logic [7:0] d, input int st);
    evt_t e;
    int n;
    if (!v) return;
    if (!m_in) begin
      if (a && k && d == K_SOF) begin
        m_in = 1; mq.delete(); m_ne = 0;
      end
      return;
    end
    if (!a) begin m_err(6, st); m_in = 0; return; end
    if (k && d == K_SOF) begin
      m_err(3, st); mq.delete(); m_ne = 0; return;
    end
    if (k && d == K_EOF) begin
      m_in = 0;
      if (mq.size() < 2) begin
        m_err(5, st);
      end else begin
        n = mq.size() - 1;
        m_emit(mq[n-1], (m_ne == 0) ? T_SINGLE : T_LAST, st);
        if (ref_crc(mq, n) == mq[n]) begin
          e.cyc = st; e.ok = 1'b1; e.err = 1'b0; e.code = 3'd0;
          exp_e.push_back(e);
          m_fc = (m_fc + 1) % (1 << CNT_W);
        end else begin
          m_err(1, st);
        end
      end
      return;
    end
    if (k) begin m_err(2, st); m_in = 0; return; end
    mq.push_back(d);
    if (mq.size() > MAX_LEN + 1) begin
      m_err(4, st); m_in = 0; return;
    end
    if (mq.size() >= 3) begin
      m_emit(mq[mq.size()-3], (m_ne == 0) ? T_FIRST : T_MID, st);
      m_ne++;
    end
  endtask

  task automatic send(input bit v, input bit a, input bit k,
                      input logic [7:0] d);
    @(negedge clk);
    #1;
    rx_valid = v; rx_aligned = a; rx_k = k; rx_data = d;
    model(v, a, k, d, cyc + 1);
  endtask

  task automatic sendb(input logic [7:0] d); send(1, 1, 0, d); endtask
  task automatic sendk(input logic [7:0] d); send(1, 1, 1, d); endtask
  task automatic gap(); send(0, 1, 0, 8'h00); endtask
  task automatic flush(); repeat (3) gap(); endtask

  task automatic send_frame(input logic [7:0] p[$],
                            input logic [7:0] cx, input bit gaps);
    logic [7:0] c;
    c = ref_crc(p, p.size()) ^ cx;
    sendk(K_SOF);
    foreach (p[i]) begin
      if (gaps) gap();
      sendb(p[i]);
    end
    if (gaps) gap();
    sendb(c);
    if (gaps) gap();
    sendk(K_EOF);
    sendk(K_IDLE);
  endtask

  task automatic check_streams(input string name);
    flush();
    chk({name, " nbytes"}, obs_b.size(), exp_b.size());
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
      chk($sformatf("%s byte%0d cyc", name, i), obs_b[i].cyc, exp_b[i].cyc);
      chk($sformatf("%s byte%0d data", name, i), obs_b[i].d, exp_b[i].d);
      chk($sformatf("%s byte%0d type", name, i), obs_b[i].t, exp_b[i].t);
    end
    chk({name, " nevents"}, obs_e.size(), exp_e.size());
    for (int i = 0; i < obs_e.size() && i < exp_e.size(); i++) begin
      chk($sformatf("%s evt%0d cyc", name, i), obs_e[i].cyc, exp_e[i].cyc);
      chk($sformatf("%s evt%0d ok", name, i), obs_e[i].ok, exp_e[i].ok);
      chk($sformatf("%s evt%0d err", name, i), obs_e[i].err, exp_e[i].err);
      chk($sformatf("%s evt%0d code", name, i), obs_e[i].code, exp_e[i].code);
    end
    chk({name, " frame_count"}, frame_count, m_fc);
    chk({name, " err_count"}, err_count, m_ec);
    obs_b.delete(); exp_b.delete(); obs_e.delete(); exp_e.delete();
  endtask

  task automatic run_random(input int nframes);
    logic [7:0] p[$];
    logic [7:0] c;
    logic [7:0] kb[4];
    int n, fpos, fk;
    kb[0] = 8'hBC; kb[1] = 8'h1C; kb[2] = 8'h3C; kb[3] = 8'hF7;
    for (int f = 0; f < nframes; f++) begin
      p.delete();
      n = $urandom_range(0, 6);
      if ($urandom_range(0, 24) == 0) n = MAX_LEN - 1 + $urandom_range(0, 2);
      for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
      c = ref_crc(p, n);
      if ($urandom_range(0, 9) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
      fk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      fpos = $urandom_range(0, n + 1);
      sendk(K_SOF);
      for (int i = 0; i <= n + 1; i++) begin
        if ($urandom_range(0, 4) == 0) gap();
        if (fk != 0 && i == fpos) begin
          case (fk)
            1: sendk(kb[$urandom_range(0, 3)]);
            2: sendk(K_SOF);
            default: send(1, 0, 1'($urandom_range(0, 1)), 8'h5A);
          endcase
        end
        if (i < n) sendb(p[i]);
        else if (i == n) sendb(c);
        else sendk(K_EOF);
      end
      repeat ($urandom_range(0, 2)) sendk(K_IDLE);
      if (f % 10 == 9) check_streams($sformatf("rand%0d", f));
    end
    check_streams("rand_end");
  endtask

  vec_t vt[6];
  logic [7:0] p[$];
  logic [1:0] et;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected done");
    $fatal(1);
  end

  initial begin
    vt[0] = '{3, {8'h1A, 8'h1B, 8'h1C, 8'h00}, 8'h00, 1'b1, 3'd0, 3};
    vt[1] = '{1, {8'hAA, 8'h00, 8'h00, 8'h00}, 8'h00, 1'b1, 3'd0, 1};
    vt[2] = '{1, {8'hAA, 8'h00, 8'h00, 8'h00}, 8'h01, 1'b0, 3'd1, 1};
    vt[3] = '{2, {8'h00, 8'hFF, 8'h00, 8'h00}, 8'h00, 1'b1, 3'd0, 2};
    vt[4] = '{4, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 8'h80, 1'b0, 3'd1, 4};
    vt[5] = '{0, {8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 1'b0, 3'd5, 0};

    repeat (3) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_type", out_type, 0);
    chk("rst frame_ok", frame_ok, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst err_code", err_code, 0);
    chk("rst frame_count", frame_count, 0);
    chk("rst err_count", err_count, 0);
    #1 rst = 1'b0;
    repeat (2) sendk(K_IDLE);

    for (int v = 0; v < 6; v++) begin
      p.delete();
      for (int i = 0; i < vt[v].n; i++) p.push_back(vt[v].p[i]);
      send_frame(p, vt[v].cx, 1'b0);
      flush();
      chk($sformatf("vec%0d nevents", v), obs_e.size(), 1);
      if (obs_e.size() == 1) begin
        chk($sformatf("vec%0d ok", v), obs_e[0].ok, vt[v].ok);
        chk($sformatf("vec%0d code", v), obs_e[0].code, vt[v].code);
      end
      chk($sformatf("vec%0d nbytes", v), obs_b.size(), vt[v].nb);
      for (int i = 0; i < vt[v].nb && i < obs_b.size(); i++) begin
        et = (vt[v].nb == 1) ? T_SINGLE : (i == 0) ? T_FIRST :
             (i == vt[v].nb - 1) ? T_LAST : T_MID;
        chk($sformatf("vec%0d data%0d", v, i), obs_b[i].d, vt[v].p[i]);
        chk($sformatf("vec%0d type%0d", v, i), obs_b[i].t, et);
      end
      if (vt[v].nb > 0 && obs_b.size() == vt[v].nb && obs_e.size() == 1)
        chk($sformatf("vec%0d last with event", v),
            obs_b[vt[v].nb-1].cyc, obs_e[0].cyc);
      check_streams($sformatf("vec%0d", v));
    end

    // unexpected K mid-frame
    sendk(K_SOF); sendb(8'h1A); sendb(8'h2A); sendb(8'h3A);
    sendk(K_IDLE); sendb(8'h2B); sendk(K_EOF); sendk(K_IDLE);
    flush();
    chk("kerr nbytes", obs_b.size(), 1);
    if (obs_b.size() == 1) begin
      chk("kerr data", obs_b[0].d, 8'h1A);
      chk("kerr type", obs_b[0].t, T_FIRST);
    end
    chk("kerr nevents", obs_e.size(), 1);
    if (obs_e.size() == 1) chk("kerr code", obs_e[0].code, 2);
    check_streams("kerr");
    p.delete(); p.push_back(8'h31); p.push_back(8'h32);
    send_frame(p, 8'h00, 1'b0);
    check_streams("after kerr");

    // payload of MAX_LEN is accepted, MAX_LEN+1 is rejected
    p.delete();
    for (int i = 0; i < MAX_LEN; i++) p.push_back(8'(i * 7 + 3));
    send_frame(p, 8'h00, 1'b0);
    flush();
    chk("maxlen nbytes", obs_b.size(), MAX_LEN);
    chk("maxlen nevents", obs_e.size(), 1);
    if (obs_e.size() == 1) chk("maxlen ok", obs_e[0].ok, 1);
    check_streams("maxlen");
    p.push_back(8'h99);
    send_frame(p, 8'h00, 1'b0);
    flush();
    chk("toolong nbytes", obs_b.size(), MAX_LEN - 1);
    chk("toolong nevents", obs_e.size(), 1);
    if (obs_e.size() == 1) chk("toolong code", obs_e[0].code, 4);
    check_streams("toolong");

    // SOF,EOF with nothing between
    sendk(K_SOF); sendk(K_EOF); sendk(K_IDLE);
    flush();
    chk("empty nevents", obs_e.size(), 1);
    if (obs_e.size() == 1) chk("empty code", obs_e[0].code, 5);
    check_streams("empty");

    // SOF inside a frame restarts it
    p.delete(); p.push_back(8'h2C);
    sendk(K_SOF); sendb(8'h1A);
    send_frame(p, 8'h00, 1'b0);
    flush();
    chk("resof nevents", obs_e.size(), 2);
    if (obs_e.size() == 2) begin
      chk("resof code", obs_e[0].code, 3);
      chk("resof ok", obs_e[1].ok, 1);
    end
    chk("resof nbytes", obs_b.size(), 1);
    if (obs_b.size() == 1) begin
      chk("resof data", obs_b[0].d, 8'h2C);
      chk("resof type", obs_b[0].t, T_SINGLE);
    end
    check_streams("resof");

    // gaps between every byte
    p.delete(); p.push_back(8'h1A); p.push_back(8'h1B); p.push_back(8'h1C);
    send_frame(p, 8'h00, 1'b1);
    flush();
    chk("gaps nbytes", obs_b.size(), 3);
    if (obs_b.size() == 3) begin
      chk("gaps data2", obs_b[2].d, 8'h1C);
      chk("gaps type0", obs_b[0].t, T_FIRST);
      chk("gaps type2", obs_b[2].t, T_LAST);
    end
    check_streams("gaps");

    // alignment lost mid-frame, and together with EOF
    sendk(K_SOF); sendb(8'h11); sendb(8'h22); sendb(8'h33);
    send(1, 0, 0, 8'h44); sendk(K_IDLE);
    sendk(K_SOF); sendb(8'h11); sendb(8'h22);
    sendb(ref_crc(p, 0)); send(1, 0, 1, K_EOF); sendk(K_IDLE);
    flush();
    chk("align nevents", obs_e.size(), 2);
    if (obs_e.size() == 2) begin
      chk("align code0", obs_e[0].code, 6);
      chk("align code1", obs_e[1].code, 6);
    end
    check_streams("align");

    // SOF while not aligned is ignored
    send(1, 0, 1, K_SOF); sendb(8'h01); sendb(8'h02);
    sendb(8'h03); sendk(K_EOF); sendk(K_IDLE);
    check_streams("unaligned idle");

    // asynchronous reset mid-frame
    sendk(K_SOF); sendb(8'h01); sendb(8'h02); sendb(8'h03);
    @(negedge clk);
    chk("prerst out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst out_data", out_data, 0);
    chk("async rst frame_count", frame_count, 0);
    chk("async rst err_count", err_count, 0);
    m_in = 0; m_fc = 0; m_ec = 0; mq.delete();
    @(negedge clk);
    #1 rst = 1'b0; rx_valid = 1'b0;
    check_streams("async rst");

    run_random(120);

    $display("End of test - %0d assertions evaluated, %0d failures",
             naso, nfail);
    $finish;
  end

endmodule
